// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_pkg
// Purpose  : Score-bar geometry, limits and FSM encoding shared with drawer.
// Revision : 1.0
// ============================================================================
package score_pkg;

  localparam int c_x_origin    = 10;
  localparam int c_y_origin    = 44;
  localparam int c_block_pitch = 5;
  localparam int c_max_score   = 40;
  localparam int c_pend_max    = 15;

  localparam int c_coord_w = 9;
  localparam int c_score_w = 6;

  localparam logic [2:0] S_IDLE           = 3'd0;
  localparam logic [2:0] S_ISSUE_CLR      = 3'd1;
  localparam logic [2:0] S_WAIT_CLR_ACK   = 3'd2;
  localparam logic [2:0] S_WAIT_CLR_DONE  = 3'd3;
  localparam logic [2:0] S_ISSUE_DRAW     = 3'd4;
  localparam logic [2:0] S_WAIT_DRAW_ACK  = 3'd5;
  localparam logic [2:0] S_WAIT_DRAW_DONE = 3'd6;

  // Left edge of block number idx; the full range stays inside 9 bits.
  function automatic logic [c_coord_w-1:0] f_block_x(
    input logic [c_coord_w-1:0] origin,
    input logic [c_coord_w-1:0] pitch,
    input logic [c_score_w-1:0] idx
  );
    return origin + c_coord_w'(idx) * pitch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_pend_cnt.sv
`default_nettype none
// ============================================================================
// Module   : score_pend_cnt
// Purpose  : Saturating up/down counter of increments not yet drawn.
// Revision : 1.0
// ============================================================================
module score_pend_cnt
  import score_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = c_pend_max
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;

  // Clear wins; a simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      if (r_count != c_max) begin
        r_count <= r_count + WIDTH'(1);
      end
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/score_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : score_sequencer
// Purpose  : Turns score pulses into one-block draw / bar-clear requests.
// Revision : 1.0
// ============================================================================
module score_sequencer
  import score_pkg::*;
#(
  parameter int X_ORIGIN    = c_x_origin,
  parameter int Y_ORIGIN    = c_y_origin,
  parameter int BLOCK_PITCH = c_block_pitch,
  parameter int MAX_SCORE   = c_max_score,
  parameter int PEND_MAX    = c_pend_max
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 score_inc,
  input  logic                 score_clear,
  input  logic                 ready_to_draw,
  output logic                 enable_start,
  output logic                 enable_clear,
  output logic [c_coord_w-1:0] block_x,
  output logic [c_coord_w-1:0] block_y,
  output logic [c_score_w-1:0] score,
  output logic                 bar_full,
  output logic                 busy
);

  localparam int c_pend_w = $clog2(PEND_MAX + 1);
  localparam int c_sum_w  = ((c_score_w > c_pend_w) ? c_score_w : c_pend_w) + 1;

  localparam logic [c_coord_w-1:0] c_x0    = c_coord_w'(X_ORIGIN);
  localparam logic [c_coord_w-1:0] c_y0    = c_coord_w'(Y_ORIGIN);
  localparam logic [c_coord_w-1:0] c_pitch = c_coord_w'(BLOCK_PITCH);
  localparam logic [c_score_w-1:0] c_full  = c_score_w'(MAX_SCORE);
  localparam logic [c_sum_w-1:0]   c_limit = c_sum_w'(MAX_SCORE);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic                 r_inc;
  logic                 r_clr;
  logic                 r_clear_pend;
  logic [c_score_w-1:0] r_score;
  logic [c_pend_w-1:0]  w_pend;
  logic [c_coord_w-1:0] r_block_x;
  logic [c_coord_w-1:0] r_block_y;
  logic [c_sum_w-1:0]   w_committed;
  logic                 w_inc_ok;
  logic                 w_in_issue_draw;
  logic                 w_in_issue_clr;
  logic                 w_start_draw;

  // Pulses are registered once so they are judged against settled counts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inc <= 1'b0;
      r_clr <= 1'b0;
    end else begin
      r_inc <= score_inc;
      r_clr <= score_clear;
    end
  end

  assign w_committed     = c_sum_w'(r_score) + c_sum_w'(w_pend);
  assign w_inc_ok        = r_inc & ~r_clr & (w_committed < c_limit);
  assign w_in_issue_draw = (r_state == S_ISSUE_DRAW);
  assign w_in_issue_clr  = (r_state == S_ISSUE_CLR);
  assign w_start_draw    = (r_state == S_IDLE) && (w_state_nxt == S_ISSUE_DRAW);

  score_pend_cnt #(
    .WIDTH (c_pend_w),
    .MAX   (PEND_MAX)
  ) u_pend_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (w_in_issue_clr),
    .i_inc   (w_inc_ok),
    .i_dec   (w_in_issue_draw),
    .o_count (w_pend)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ready_to_draw) begin
          if (r_clear_pend) begin
            w_state_nxt = S_ISSUE_CLR;
          end else if (w_pend != '0) begin
            w_state_nxt = S_ISSUE_DRAW;
          end
        end
      end
      S_ISSUE_CLR:      w_state_nxt = S_WAIT_CLR_ACK;
      S_WAIT_CLR_ACK:   if (!ready_to_draw) w_state_nxt = S_WAIT_CLR_DONE;
      S_WAIT_CLR_DONE:  if (ready_to_draw)  w_state_nxt = S_IDLE;
      S_ISSUE_DRAW:     w_state_nxt = S_WAIT_DRAW_ACK;
      S_WAIT_DRAW_ACK:  if (!ready_to_draw) w_state_nxt = S_WAIT_DRAW_DONE;
      S_WAIT_DRAW_DONE: if (ready_to_draw)  w_state_nxt = S_IDLE;
      default:          w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A clear that lands mid-draw is remembered and served once back in idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clear_pend <= 1'b0;
    end else if (r_clr) begin
      r_clear_pend <= 1'b1;
    end else if (w_in_issue_clr) begin
      r_clear_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_score <= '0;
    end else if (w_in_issue_clr) begin
      r_score <= '0;
    end else if (w_in_issue_draw) begin
      r_score <= r_score + c_score_w'(1);
    end
  end

  // Position uses the score before this draw bumps it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_block_x <= c_x0;
      r_block_y <= c_y0;
    end else if (w_start_draw) begin
      r_block_x <= f_block_x(c_x0, c_pitch, r_score);
      r_block_y <= c_y0;
    end
  end

  assign enable_start = w_in_issue_draw;
  assign enable_clear = w_in_issue_clr;
  assign block_x      = r_block_x;
  assign block_y      = r_block_y;
  assign score        = r_score;
  assign bar_full     = (r_score == c_full);
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_score_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_sequencer
// Purpose  : Self-checking bench for score_sequencer with a modelled drawer.
// Revision : 1.0
// ============================================================================
module tb_score_sequencer;

  localparam int X0   = 10;
  localparam int Y0   = 44;
  localparam int PITCH = 5;
  localparam int MAXS = 40;

  logic       clk;
  logic       resetn;
  logic       score_inc;
  logic       score_clear;
  logic       ready_to_draw;
  logic       enable_start;
  logic       enable_clear;
  logic [8:0] block_x;
  logic [8:0] block_y;
  logic [5:0] score;
  logic       bar_full;
  logic       busy;

  int n_vec = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_clear = 0;
  int n_overlap = 0;
  int mdl_drawn = 0;
  int last_x = 0;

  bit drw_manual = 1'b0;
  bit man_ready = 1'b1;
  bit auto_ready = 1'b1;
  int drw_lat = 0;
  int drw_busy = 3;

  assign ready_to_draw = drw_manual ? man_ready : auto_ready;

  score_sequencer dut (
    .clk           (clk),
    .resetn        (resetn),
    .score_inc     (score_inc),
    .score_clear   (score_clear),
    .ready_to_draw (ready_to_draw),
    .enable_start  (enable_start),
    .enable_clear  (enable_clear),
    .block_x       (block_x),
    .block_y       (block_y),
    .score         (score),
    .bar_full      (bar_full),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      score_inc = 1'b1;
      tick();
      score_inc = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic pulse_clear();
    score_clear = 1'b1;
    tick();
    score_clear = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0;
    int cyc = 0;
    while (quiet < 6 && cyc < 4000) begin
      tick();
      cyc++;
      if (!busy && ready_to_draw) quiet++;
      else quiet = 0;
    end
    check("drain_settle", (quiet >= 6) ? 1 : 0, 1);
  endtask

  task automatic wait_start(input string name);
    int cyc = 0;
    while (!enable_start && cyc < 50) begin
      tick();
      cyc++;
    end
    check(name, enable_start, 1);
  endtask

  // Drawer: drops ready after a latency, stays busy, then returns ready.
  initial begin
    forever begin
      tick();
      if (!drw_manual && resetn && (enable_start || enable_clear)) begin
        repeat (drw_lat) tick();
        auto_ready = 1'b0;
        repeat (drw_busy) tick();
        auto_ready = 1'b1;
      end
    end
  end

  // Scoreboard: every draw must land at the next slot counted from the last clear.
  always @(negedge clk) begin
    if (!resetn) begin
      mdl_drawn = 0;
    end else begin
      if (enable_start && enable_clear) n_overlap++;
      if (enable_start) begin
        check("draw_x", block_x, X0 + PITCH * mdl_drawn);
        check("draw_y", block_y, Y0);
        check("draw_within_bar", (mdl_drawn < MAXS) ? 1 : 0, 1);
        mdl_drawn++;
        n_start++;
        last_x = block_x;
      end
      if (enable_clear) begin
        mdl_drawn = 0;
        n_clear++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, expected $finish before it");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit clr;
    int n_inc;
    int gap;
    int exp_score;
    int exp_x;
    bit exp_full;
    int exp_draws;
  } vec_t;

  vec_t tv[10];

  initial begin
    int s0;
    int c0;
    int mdl_score;
    int n;

    tv[0] = '{1'b1, 1,  0, 1,  10,  1'b0, 1};
    tv[1] = '{1'b0, 2,  0, 3,  20,  1'b0, 2};
    tv[2] = '{1'b0, 3,  5, 6,  35,  1'b0, 3};
    tv[3] = '{1'b0, 10, 0, 16, 85,  1'b0, 10};
    tv[4] = '{1'b0, 14, 1, 30, 155, 1'b0, 14};
    tv[5] = '{1'b0, 9,  2, 39, 200, 1'b0, 9};
    tv[6] = '{1'b0, 1,  0, 40, 205, 1'b1, 1};
    tv[7] = '{1'b0, 3,  0, 40, 205, 1'b1, 0};
    tv[8] = '{1'b1, 0,  0, 0,  205, 1'b0, 0};
    tv[9] = '{1'b1, 4,  3, 4,  25,  1'b0, 4};

    resetn = 1'b0;
    score_inc = 1'b0;
    score_clear = 1'b0;
    repeat (3) tick();

    check("rst_enable_start", enable_start, 0);
    check("rst_enable_clear", enable_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_score", score, 0);
    check("rst_bar_full", bar_full, 0);
    check("rst_block_x", block_x, X0);
    check("rst_block_y", block_y, Y0);
    resetn = 1'b1;
    tick();

    // Latency: inc sampled at edge N gives enable_start after edge N+2.
    score_inc = 1'b1;
    tick();
    score_inc = 1'b0;
    tick();
    check("lat_after_n1", enable_start, 0);
    tick();
    check("lat_after_n2", enable_start, 1);
    check("lat_block_x", block_x, X0);
    check("lat_block_y", block_y, Y0);
    drain();
    check("lat_score", score, 1);

    // inc and clear together: only the clear is served.
    s0 = n_start;
    c0 = n_clear;
    score_inc = 1'b1;
    score_clear = 1'b1;
    tick();
    score_inc = 1'b0;
    score_clear = 1'b0;
    drain();
    check("same_cyc_starts", n_start - s0, 0);
    check("same_cyc_clears", n_clear - c0, 1);
    check("same_cyc_score", score, 0);

    // Three back-to-back incs with a slow drawer.
    drw_busy = 20;
    s0 = n_start;
    pulse_inc(3, 0);
    drain();
    check("slow3_starts", n_start - s0, 3);
    check("slow3_score", score, 3);
    check("slow3_last_x", last_x, 20);

    // Clear during a draw waits for the draw, then discards the backlog.
    s0 = n_start;
    c0 = n_clear;
    pulse_inc(3, 0);
    wait_start("middraw_start_seen");
    repeat (5) tick();
    check("middraw_busy", busy, 1);
    pulse_clear();
    repeat (6) tick();
    check("middraw_clear_held", n_clear - c0, 0);
    drain();
    check("middraw_clears", n_clear - c0, 1);
    check("middraw_starts", n_start - s0, 1);
    check("middraw_score", score, 0);

    drw_busy = 3;
    for (int i = 0; i < 10; i++) begin
      s0 = n_start;
      if (tv[i].clr) begin
        pulse_clear();
        drain();
      end
      pulse_inc(tv[i].n_inc, tv[i].gap);
      drain();
      check($sformatf("vec%0d_score", i), score, tv[i].exp_score);
      check($sformatf("vec%0d_full", i), bar_full, tv[i].exp_full);
      check($sformatf("vec%0d_block_x", i), block_x, tv[i].exp_x);
      check($sformatf("vec%0d_draws", i), n_start - s0, tv[i].exp_draws);
    end

    // Pending saturation: 20 incs with the drawer held busy keep only 15.
    pulse_clear();
    drain();
    drw_manual = 1'b1;
    man_ready = 1'b0;
    s0 = n_start;
    pulse_inc(20, 0);
    repeat (4) tick();
    check("sat_idle_while_not_ready", busy, 0);
    check("sat_no_start_yet", n_start - s0, 0);
    drw_manual = 1'b0;
    drain();
    check("sat_starts", n_start - s0, 15);
    check("sat_score", score, 15);

    // 45 spaced increments fill the bar at exactly 40.
    pulse_clear();
    drain();
    drw_busy = 2;
    s0 = n_start;
    pulse_inc(45, 6);
    drain();
    check("full45_starts", n_start - s0, 40);
    check("full45_last_x", last_x, 205);
    check("full45_bar_full", bar_full, 1);
    check("full45_score", score, 40);
    s0 = n_start;
    pulse_inc(3, 2);
    drain();
    check("full_extra_starts", n_start - s0, 0);
    check("full_extra_score", score, 40);

    // Asynchronous reset while waiting for the draw acknowledge.
    pulse_clear();
    drain();
    drw_manual = 1'b1;
    man_ready = 1'b1;
    pulse_inc(3, 0);
    wait_start("rst_mid_start_seen");
    tick();
    check("rst_mid_pre_busy", busy, 1);
    check("rst_mid_pre_score", score, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_enable_start", enable_start, 0);
    check("rst_mid_enable_clear", enable_clear, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_score", score, 0);
    check("rst_mid_block_x", block_x, X0);
    tick();
    resetn = 1'b1;
    drw_manual = 1'b0;
    tick();
    s0 = n_start;
    pulse_inc(1, 0);
    drain();
    check("rst_after_starts", n_start - s0, 1);
    check("rst_after_last_x", last_x, X0);
    check("rst_after_score", score, 1);

    // Randomized bursts against a count-level model of the bar.
    pulse_clear();
    drain();
    mdl_score = 0;
    for (int r = 0; r < 25; r++) begin
      drw_lat = $urandom_range(0, 2);
      drw_busy = $urandom_range(2, 6);
      if ($urandom_range(0, 5) == 0) begin
        pulse_clear();
        drain();
        mdl_score = 0;
      end else begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
          score_inc = 1'b1;
          tick();
          score_inc = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        mdl_score = (mdl_score + n > MAXS) ? MAXS : mdl_score + n;
      end
      check($sformatf("rand%0d_score", r), score, mdl_score);
      check($sformatf("rand%0d_full", r), bar_full, (mdl_score == MAXS) ? 1 : 0);
    end

    check("start_clear_overlap", n_overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_sequencer.md
SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): X_ORIGIN, 10, bar left x; Y_ORIGIN, 44, bar top y; BLOCK_PITCH, 5, x step per block; MAX_SCORE, 40, blocks in a full bar; PEND_MAX, 15, pending-increment saturation.
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  single clock, rising edge;
  resetn  in  1  reset, asynchronous, active-low;
  score_inc  in  1  one-cycle pulse, word typed correctly;
  score_clear  in  1  one-cycle pulse, new game, wipe bar;
  ready_to_draw  in  1  high while the downstream drawer is idle;
  enable_start  out  1  one-cycle request to draw one block;
  enable_clear  out  1  one-cycle request to clear the bar region;
  block_x  out  9  x of the requested block;
  block_y  out  9  y of the requested block;
  score  out  6  blocks drawn or committed, 0..MAX_SCORE;
  bar_full  out  1  high when score == MAX_SCORE;
  busy  out  1  high in any state other than S_IDLE.

Function
REQ-003 SHALL keep a pending-increment count: +1 per score_inc; -1 per draw issue; unchanged when both occur in one cycle; saturate at PEND_MAX, excess dropped.
REQ-004 SHALL drop score_inc when score + pending >= MAX_SCORE.
REQ-005 SHALL latch score_clear into clear_pend; a score_inc in the same cycle is dropped.
REQ-006 SHALL implement these FSM states: S_IDLE, S_ISSUE_CLR, S_WAIT_CLR_ACK, S_WAIT_CLR_DONE, S_ISSUE_DRAW, S_WAIT_DRAW_ACK, S_WAIT_DRAW_DONE.
REQ-007 S_IDLE: if clear_pend and ready_to_draw, SHALL go to S_ISSUE_CLR; else if pending > 0 and ready_to_draw, SHALL go to S_ISSUE_DRAW; clear has priority.
REQ-008 S_ISSUE_CLR SHALL assert enable_clear for exactly one cycle, zero score and pending, clear clear_pend, and go to S_WAIT_CLR_ACK.
REQ-009 S_ISSUE_DRAW SHALL assert enable_start for exactly one cycle, decrement pending, increment score, and go to S_WAIT_DRAW_ACK.
REQ-010 Entry into S_ISSUE_DRAW SHALL register block_x = X_ORIGIN + score*BLOCK_PITCH (pre-increment score) and block_y = Y_ORIGIN; both SHALL hold until the next issue.
REQ-011 S_WAIT_*_ACK SHALL wait for ready_to_draw == 0 and then go to S_WAIT_*_DONE; S_WAIT_*_DONE SHALL wait for ready_to_draw == 1 and then go to S_IDLE.
REQ-012 score_clear arriving mid-draw SHALL NOT abort the draw; the clear is served from S_IDLE after the draw completes; pending is discarded at clear issue.
REQ-013 enable_start and enable_clear SHALL be Moore outputs and SHALL never be high together.
REQ-014 Latency: score_inc sampled at edge N with the FSM idle and ready high SHALL produce enable_start high in the cycle after edge N+2.
REQ-015 block_x arithmetic SHALL be 9-bit; the maximum value 10 + 39*5 = 205 SHALL not overflow.

Reset
REQ-016 resetn low SHALL asynchronously force state S_IDLE; score = 0, pending = 0, clear_pend = 0, block_x = X_ORIGIN, block_y = Y_ORIGIN, and all outputs low.
REQ-017 Reset mid-handshake SHALL leave no residual request; the first operation after release SHALL start from S_IDLE.

Structure
REQ-018 score_pkg SHALL hold X_ORIGIN, Y_ORIGIN, BLOCK_PITCH, MAX_SCORE, PEND_MAX and the state encoding, shared with the drawer.
REQ-019 SHALL instantiate one sub-module, score_pend_cnt: a saturating up/down counter with simultaneous-event rules.

Verification
REQ-020 Single score_inc with ready high -> enable_start one cycle after edge N+2, block_x = 10, block_y = 44, score = 1.
REQ-021 Three score_inc pulses on consecutive cycles, drawer modelled busy 20 cycles per block -> three enable_start pulses with block_x = 10, 15, 20; score = 3.
REQ-022 score_clear during S_WAIT_DRAW_DONE -> no enable_clear until ready returns; then one enable_clear pulse, score = 0, pending = 0.
REQ-023 score_inc and score_clear in the same cycle from S_IDLE -> only enable_clear; score = 0; no enable_start.
REQ-024 45 increments -> exactly 40 draws, last block_x = 205, bar_full = 1; further score_inc pulses ignored.
REQ-025 resetn pulsed low in S_WAIT_DRAW_ACK -> all outputs 0 immediately, score = 0; a new score_inc afterwards draws at block_x = 10.
